mips150_uart_mmio: RTL

Parametrised, memory-mapped serial port for the MIPS150 core. It replaces the fixed single-byte serial path on FPGA_SERIAL_RX/FPGA_SERIAL_TX with independent RX and TX FIFOs, configurable frame width and baud rate, and sticky error flags. It sits on the datapath's I/O address decode, alongside data memory, and is polled by software through four word-aligned registers.

---
 rtl/mips150_io_pkg.sv | 26 ++
 rtl/uart_fifo.sv | 44 ++++
 rtl/mips150_uart_mmio.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mips150_io_pkg.sv
// Shared constants for the MIPS150 memory-mapped UART: register offsets,
// STATUS/ERR bit positions and the RX/TX frame state encoding.
package mips150_io_pkg;

    localparam logic [3:0] UART_STATUS = 4'h0;
    localparam logic [3:0] UART_RX     = 4'h4;
    localparam logic [3:0] UART_TX     = 4'h8;
    localparam logic [3:0] UART_ERR    = 4'hC;

    localparam int ST_TX_READY = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_TX_BUSY  = 2;

    localparam int ERR_RX_OVF  = 0;
    localparam int ERR_TX_OVF  = 1;
    localparam int ERR_FRAME   = 2;
    localparam int ERR_OCC_LSB = 8;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    // Occupancy field in ERR is 4 bits wide; deeper FIFOs report 15.
    function automatic logic [3:0] sat_occ(input int unsigned n);
        return (n > 15) ? 4'hF : n[3:0];
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop in the same cycle frees
// room for a push even when full.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count   = wptr_q - rptr_q;
    assign rdata   = mem_q[rptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mips150_uart_mmio.sv
// Polled UART for the MIPS150 I/O window: RX/TX FIFOs, fixed-ratio baud
// timing, sticky error flags and a 1-cycle registered read port.
module mips150_uart_mmio
    import mips150_io_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        FPGA_SERIAL_RX,
    output logic        FPGA_SERIAL_TX
);
    localparam int SYMBOL_EDGE = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF        = SYMBOL_EDGE / 2;
    localparam int CW          = $clog2(SYMBOL_EDGE);
    localparam int BW          = $clog2(DATA_BITS);
    localparam int OW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] SYM_END  = CW'(SYMBOL_EDGE - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic [3:0]           reg_sel;
    logic                 sw_pop, sw_push, err_clr;
    logic [DATA_BITS-1:0] rx_head, tx_head;
    logic                 rx_full, rx_empty, tx_full, tx_empty;
    logic [OW-1:0]        rx_count, tx_count;
    logic                 rx_push, rx_ferr, rx_ovf_set, tx_pop, tx_ovf_set;
    logic [2:0]           err_q, err_d;
    logic [31:0]          rdata_q, rdata_d, status_w, err_w;

    uart_state_e          rx_state_q, tx_state_q;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CW-1:0]        rx_cnt_q, tx_cnt_q;
    logic [BW-1:0]        rx_idx_q, tx_idx_q;
    logic [DATA_BITS-1:0] rx_shift_q, tx_shift_q;
    logic                 tx_q;

    assign reg_sel = {addr[3:2], 2'b00};
    assign sw_pop  = re && (reg_sel == UART_RX);
    assign sw_push = we && (reg_sel == UART_TX);
    assign err_clr = we && (reg_sel == UART_ERR);

    assign rx_push    = (rx_state_q == S_STOP) && (rx_cnt_q == SYM_END) && rx_s2_q;
    assign rx_ferr    = (rx_state_q == S_STOP) && (rx_cnt_q == SYM_END) && !rx_s2_q;
    assign rx_ovf_set = rx_push && rx_full && !sw_pop;
    assign tx_pop     = !tx_empty && ((tx_state_q == S_IDLE) ||
                        ((tx_state_q == S_STOP) && (tx_cnt_q == SYM_END)));
    assign tx_ovf_set = sw_push && tx_full && !tx_pop;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(sw_pop), .wdata(rx_shift_q),
        .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(sw_push), .pop(tx_pop), .wdata(wdata[DATA_BITS-1:0]),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    always_comb begin
        status_w = '0;
        status_w[ST_TX_READY] = !tx_full;
        status_w[ST_RX_VALID] = !rx_empty;
        status_w[ST_TX_BUSY]  = (tx_state_q != S_IDLE) || !tx_empty;
        err_w = '0;
        err_w[2:0] = err_q;
        err_w[ERR_OCC_LSB +: 4] = sat_occ(32'(rx_count));
        // Same-cycle set beats clear so an event is never lost to a W1C.
        err_d = (err_q & ~(err_clr ? wdata[2:0] : 3'b000));
        err_d[ERR_RX_OVF] = err_d[ERR_RX_OVF] | rx_ovf_set;
        err_d[ERR_TX_OVF] = err_d[ERR_TX_OVF] | tx_ovf_set;
        err_d[ERR_FRAME]  = err_d[ERR_FRAME]  | rx_ferr;
        rdata_d = rdata_q;
        if (re) begin
            case (reg_sel)
                UART_STATUS: rdata_d = status_w;
                UART_RX:     rdata_d = rx_empty ? 32'd0 : {{(32-DATA_BITS){1'b0}}, rx_head};
                UART_ERR:    rdata_d = err_w;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q   <= FPGA_SERIAL_RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            case (rx_state_q)
                S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                    rx_state_q <= S_START;
                    rx_cnt_q   <= '0;
                end
                S_START: if (rx_cnt_q == HALF_END) begin
                    rx_cnt_q   <= '0;
                    rx_idx_q   <= '0;
                    rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                end else rx_cnt_q <= rx_cnt_q + 1'b1;
                S_DATA: if (rx_cnt_q == SYM_END) begin
                    rx_cnt_q   <= '0;
                    rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == LAST_BIT) rx_state_q <= S_STOP;
                    else                      rx_idx_q   <= rx_idx_q + 1'b1;
                end else rx_cnt_q <= rx_cnt_q + 1'b1;
                S_STOP: if (rx_cnt_q == SYM_END) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= S_IDLE;
                end else rx_cnt_q <= rx_cnt_q + 1'b1;
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                S_IDLE: if (tx_pop) begin
                    tx_state_q <= S_START;
                    tx_cnt_q   <= '0;
                    tx_shift_q <= tx_head;
                    tx_q       <= 1'b0;
                end
                S_START: if (tx_cnt_q == SYM_END) begin
                    tx_state_q <= S_DATA;
                    tx_cnt_q   <= '0;
                    tx_idx_q   <= '0;
                    tx_q       <= tx_shift_q[0];
                end else tx_cnt_q <= tx_cnt_q + 1'b1;
                S_DATA: if (tx_cnt_q == SYM_END) begin
                    tx_cnt_q <= '0;
                    if (tx_idx_q == LAST_BIT) begin
                        tx_state_q <= S_STOP;
                        tx_q       <= 1'b1;
                    end else begin
                        tx_idx_q   <= tx_idx_q + 1'b1;
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_q       <= tx_shift_q[1];
                    end
                end else tx_cnt_q <= tx_cnt_q + 1'b1;
                // Chain straight into the next start bit when more data waits.
                S_STOP: if (tx_cnt_q == SYM_END) begin
                    tx_cnt_q <= '0;
                    if (tx_pop) begin
                        tx_state_q <= S_START;
                        tx_shift_q <= tx_head;
                        tx_q       <= 1'b0;
                    end else begin
                        tx_state_q <= S_IDLE;
                        tx_q       <= 1'b1;
                    end
                end else tx_cnt_q <= tx_cnt_q + 1'b1;
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    assign rdata          = rdata_q;
    assign FPGA_SERIAL_TX = tx_q;

    logic unused_bits;
    assign unused_bits = ^{wdata[31:DATA_BITS], addr[1:0], tx_count};

endmodule
